mem_stage_dcache: RTL

- Memory-stage data cache controller. It consumes the execute-to-memory pipeline register outputs (address, store data, MemWrite, MemCtrl, valid) and returns load data to the memory-to-writeback register.
- It drives a stall request that the hazard logic inverts into the `en` input of the upstream pipeline registers.
- Organisation: direct-mapped, one 32-bit word per line, write-through, no-write-allocate.
- It talks to backing memory over a req/ack handshake.

---
 rtl/mem_stage_dcache.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_dcache.sv
// Memory-stage data cache: direct-mapped, one 32-bit word per line,
// write-through, no-write-allocate. Loads that hit return data in the
// same cycle. Load misses refill the line from backing memory. Every
// store is written through to memory over a req/ack handshake.
module mem_stage_dcache #(
  parameter int DATA_WIDTH     = 32,
  parameter int INDEX_WIDTH    = 4,
  parameter int MEM_CTRL_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_m,
  input  logic                      MemRead_m,
  input  logic                      MemWrite_m,
  input  logic [MEM_CTRL_WIDTH-1:0] MemCtrl_m,
  input  logic [DATA_WIDTH-1:0]     ALUResult_m,
  input  logic [DATA_WIDTH-1:0]     WriteData_m,
  output logic [DATA_WIDTH-1:0]     ReadData_m,
  output logic                      stall_req,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [DATA_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [3:0]                mem_wstrb,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = DATA_WIDTH - INDEX_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t state, next_state;

  logic [TAG_WIDTH-1:0]   tag_arr  [LINES];
  logic [DATA_WIDTH-1:0]  data_arr [LINES];
  logic [LINES-1:0]       valid_q;
  logic                   done_q;

  // Request fields captured when a transaction starts, held until ack.
  logic [DATA_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [3:0]             wstrb_q;

  logic [1:0]             offset;
  logic [INDEX_WIDTH-1:0] index;
  logic [TAG_WIDTH-1:0]   tag;
  logic                   hit;
  logic                   access;
  logic [DATA_WIDTH-1:0]  cache_word;
  logic [DATA_WIDTH-1:0]  word_addr;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [3:0]             st_strb;
  logic [DATA_WIDTH-1:0]  st_wdata;

  logic [INDEX_WIDTH-1:0] h_index;
  logic [TAG_WIDTH-1:0]   h_tag;
  logic                   held_hit;
  logic [DATA_WIDTH-1:0]  merged_word;

  assign offset     = ALUResult_m[1:0];
  assign index      = ALUResult_m[INDEX_WIDTH+1:2];
  assign tag        = ALUResult_m[DATA_WIDTH-1:INDEX_WIDTH+2];
  assign hit        = valid_q[index] && (tag_arr[index] == tag);
  assign access     = valid_m && (MemRead_m || MemWrite_m);
  assign cache_word = data_arr[index];
  assign word_addr  = {ALUResult_m[DATA_WIDTH-1:2], 2'b00};

  assign h_index    = addr_q[INDEX_WIDTH+1:2];
  assign h_tag      = addr_q[DATA_WIDTH-1:INDEX_WIDTH+2];
  assign held_hit   = valid_q[h_index] && (tag_arr[h_index] == h_tag);

  assign mem_req    = (state != IDLE);
  assign mem_we     = (state == WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;

  // Select and extend the addressed byte/half of the cached word for loads.
  always_comb begin
    byte_sel = 8'(cache_word >> {offset, 3'b000});
    half_sel = offset[1] ? cache_word[31:16] : cache_word[15:0];
    case (MemCtrl_m)
      3'b000:  ReadData_m = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  ReadData_m = {{16{half_sel[15]}}, half_sel};
      3'b100:  ReadData_m = {24'b0, byte_sel};
      3'b101:  ReadData_m = {16'b0, half_sel};
      default: ReadData_m = cache_word;
    endcase
  end

  // Build byte strobes and lane-replicated store data from the store size.
  always_comb begin
    case (MemCtrl_m[1:0])
      2'b00: begin
        st_strb  = 4'b0001 << offset;
        st_wdata = {4{WriteData_m[7:0]}};
      end
      2'b01: begin
        st_strb  = offset[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{WriteData_m[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_wdata = WriteData_m;
      end
    endcase
  end

  // Merge the strobed bytes of the held store into the resident word.
  always_comb begin
    merged_word = data_arr[h_index];
    for (int i = 0; i < 4; i++) begin
      if (wstrb_q[i]) merged_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Next-state and stall decode; a completed store is released via done_q.
  always_comb begin
    next_state = state;
    stall_req  = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (MemWrite_m) begin
            if (!done_q) begin
              stall_req  = 1'b1;
              next_state = WRITE;
            end
          end else if (!hit) begin
            stall_req  = 1'b1;
            next_state = REFILL;
          end
        end
      end
      REFILL, WRITE: begin
        stall_req = 1'b1;
        if (mem_ack) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Capture the request fields when leaving IDLE so they stay stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (state == IDLE) begin
      if (next_state == REFILL) begin
        addr_q  <= word_addr;
        wstrb_q <= '0;
      end else if (next_state == WRITE) begin
        addr_q  <= word_addr;
        wdata_q <= st_wdata;
        wstrb_q <= st_strb;
      end
    end
  end

  // Flag a just-completed store until the pipeline advances past it.
  always_ff @(posedge clk) begin
    if (!rst_n)                            done_q <= 1'b0;
    else if (state == WRITE && mem_ack)    done_q <= 1'b1;
    else if (state == IDLE && !stall_req)  done_q <= 1'b0;
  end

  // Line valid bits, set when a refill completes.
  always_ff @(posedge clk) begin
    if (!rst_n)                          valid_q          <= '0;
    else if (state == REFILL && mem_ack) valid_q[h_index] <= 1'b1;
  end

  // Tag/data arrays: fill on refill ack, merge on a store ack that hits.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) begin
      tag_arr[h_index]  <= h_tag;
      data_arr[h_index] <= mem_rdata;
    end else if (state == WRITE && mem_ack && held_hit) begin
      data_arr[h_index] <= merged_word;
    end
  end

endmodule
